// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit register between N cores.
// Optional lock/ownership feature enabled by defining ARB_LOCK_EN.
module shared_reg_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] dataIn,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]       lock,
`endif
  output logic [N-1:0]       ack,
  output logic [N-1:0]       grant,
  output logic               regWrEn,
  output logic [WIDTH-1:0]   regDataIn,
  output logic               busy
);

  localparam int PW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t           state_r;
  state_t           nextState_s;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    winner_r;
  logic [PW-1:0]    win_s;
  logic             found_s;
  logic [N-1:0]     eligible_s;
  logic [N-1:0]     grant_r;
  logic [N-1:0]     nextGrant_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] nextData_s;
  logic             wrEn_r;
  logic             busy_r;
  int               idx_s;

`ifdef ARB_LOCK_EN
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic          lockValid_r;
  logic [PW-1:0] lockId_r;

  // While the owner holds its lock only its request competes
  always_comb begin
    eligible_s = req;
    if (lockValid_r && lock[lockId_r]) begin
      eligible_s = req & (ONE_HOT0 << lockId_r);
    end else begin
      eligible_s = req;
    end
  end

  // Ownership is taken in the owner's write cycle and dropped when lock falls
  always_ff @(posedge clk) begin
    if (rst) begin
      lockValid_r <= 1'b0;
      lockId_r    <= '0;
    end else if (state_r == WRITE) begin
      lockValid_r <= lock[winner_r];
      lockId_r    <= winner_r;
    end else if (lockValid_r && !lock[lockId_r]) begin
      lockValid_r <= 1'b0;
    end else begin
      lockValid_r <= lockValid_r;
      lockId_r    <= lockId_r;
    end
  end
`else
  // Pure round-robin: every request competes
  always_comb begin
    eligible_s = req;
  end
`endif

  // Scan ptr+1, ptr+2, ... modulo N for the first eligible requester
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = 0;
    for (int k = 1; k <= N; k++) begin
      idx_s = (int'(ptr_r) + k) % N;
      if (!found_s && eligible_s[idx_s]) begin
        found_s = 1'b1;
        win_s   = PW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next state and next registered outputs
  always_comb begin
    nextState_s = state_r;
    nextGrant_s = '0;
    nextData_s  = '0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          nextState_s        = WRITE;
          nextGrant_s[win_s] = 1'b1;
          nextData_s         = dataIn[int'(win_s)*WIDTH +: WIDTH];
        end else begin
          nextState_s = IDLE;
        end
      end
      WRITE:   nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State, pointer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= PW'(N-1);
      winner_r <= '0;
      grant_r  <= '0;
      data_r   <= '0;
      wrEn_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r <= nextState_s;
      grant_r <= nextGrant_s;
      data_r  <= nextData_s;
      wrEn_r  <= (nextState_s == WRITE);
      busy_r  <= (nextState_s == WRITE);
      if (state_r == IDLE && found_s) begin
        winner_r <= win_s;
      end else begin
        winner_r <= winner_r;
      end
      if (state_r == WRITE) begin
        ptr_r <= winner_r;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  assign ack       = grant_r;
  assign grant     = grant_r;
  assign regWrEn   = wrEn_r;
  assign regDataIn = data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter (N=4, WIDTH=12, default build).
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] dataIn;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           regWrEn;
  logic [W-1:0]   regDataIn;
  logic           busy;

  shared_reg_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .dataIn(dataIn),
    .ack(ack), .grant(grant), .regWrEn(regWrEn), .regDataIn(regDataIn), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [N-1:0] g; logic [W-1:0] d;} exp_t;
  typedef struct {logic [N-1:0] g; logic [W-1:0] d; int c;} rec_t;

  exp_t expQ[$];
  rec_t logQ[$];
  int   checkCnt = 0;
  int   passCnt  = 0;
  int   cycle    = 0;
  bit   autoDrop = 1'b1;
  int   mPtr     = N-1;
  bit   mBusy    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: one arbitration per write, then one turnaround cycle
  initial begin
    int w;
    forever begin
      @(posedge clk);
      cycle++;
      if (rst) begin
        mBusy = 1'b0;
        mPtr  = N-1;
      end else if (mBusy) begin
        mBusy = 1'b0;
      end else if (req != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req[(mPtr+k)%N]) w = (mPtr+k)%N;
        end
        expQ.push_back('{g: N'(1 << w), d: dataIn[w*W +: W]});
        mBusy = 1'b1;
        mPtr  = w;
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on every write
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("invariant", {31'd0, (ack === grant) && $onehot0(grant) &&
                               (regWrEn === (|grant)) && (busy === regWrEn)}, 32'd1);
      if (regWrEn === 1'b1) begin
        logQ.push_back('{g: grant, d: regDataIn, c: cycle});
        if (expQ.size() == 0) begin
          checkCnt++;
          $display("FAIL unexpectedWrite: got grant %b expected no write", grant);
        end else begin
          e = expQ.pop_front();
          chk("grant", grant, e.g);
          chk("regDataIn", regDataIn, e.d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (autoDrop) req = req & ~ack;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (req == '0 && expQ.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int c0;
    bit seen;
    rst = 1'b1; req = '0; dataIn = '0;
    repeat (2) step();
    rst = 1'b0;
    chk("rstGrant", grant, 32'd0);
    chk("rstAck", ack, 32'd0);
    chk("rstData", regDataIn, 32'd0);
    chk("rstBusy", busy, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idleWrEn", regWrEn, 32'd0);
    end

    // single request from core 1
    doReset();
    logQ.delete();
    req[1] = 1'b1; dataIn[1*W +: W] = 12'd43;
    c0 = cycle;
    drain("drainSingle");
    chk("singleCount", logQ.size(), 32'd1);
    if (logQ.size() >= 1) begin
      chk("singleGrant", logQ[0].g, 32'b0010);
      chk("singleData", logQ[0].d, 32'd43);
      chk("singleLatency", logQ[0].c - c0, 32'd1);
    end
    chk("singleIdleWrEn", regWrEn, 32'd0);

    // all four request together after reset
    doReset();
    logQ.delete();
    req = 4'b1111;
    for (int i = 0; i < N; i++) dataIn[i*W +: W] = W'(12'h100 + i);
    c0 = cycle;
    drain("drainAll");
    chk("allCount", logQ.size(), 32'd4);
    for (int i = 0; i < N && i < logQ.size(); i++) begin
      chk("allGrant", logQ[i].g, 32'(1 << i));
      chk("allData", logQ[i].d, 32'(12'h100 + i));
      chk("allSpacing", logQ[i].c - c0, 32'(1 + 2*i));
    end

    // pointer at 3: wrap to core 0 before core 3
    logQ.delete();
    req = 4'b1001;
    dataIn[0*W +: W] = 12'h0AA; dataIn[3*W +: W] = 12'h0BB;
    drain("drainWrap");
    chk("wrapCount", logQ.size(), 32'd2);
    if (logQ.size() == 2) begin
      chk("wrapFirst", logQ[0].g, 32'b0001);
      chk("wrapSecond", logQ[1].g, 32'b1000);
      chk("wrapData", logQ[1].d, 32'h0BB);
    end

    // reset asserted during core 2's write cycle
    logQ.delete();
    autoDrop = 1'b0;
    req = 4'b0100; dataIn[2*W +: W] = 12'h2A5;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ack[2]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rstWriteSeen", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstWriteGrant", grant, 32'd0);
    chk("rstWriteWrEn", regWrEn, 32'd0);
    chk("rstWriteBusy", busy, 32'd0);
    step();
    chk("regrantGrant", grant, 32'b0100);
    chk("regrantData", regDataIn, 32'h2A5);
    req = '0;
    autoDrop = 1'b1;
    drain("drainRst");
    chk("rstWriteCount", logQ.size(), 32'd2);

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            dataIn[i*W +: W] = W'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    drain("drainRandom");
    chk("queueEmpty", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
